fft_frame_ctrl: RTL and testbench

Frame sequencer for the 32-point FFT pipeline. It sits between the sample source and STAGE1. On the input side it groups the incoming samples into contiguous 32-sample frames. It pads any gaps with zeros and, after the last frame, auto-flushes the pipeline with zero samples. On the output side it tags the results from the last stage with frame start/end markers and the bit-reversed bin index.

---
 rtl/fft_pkg.sv | 14 +
 rtl/fft_bitrev.sv | 14 +
 rtl/fft_frame_ctrl.sv | 128 ++++++++++++
 tb/tb_fft_frame_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the 32-point FFT
// frame controller and its helpers.
package fft_pkg;

  localparam int N     = 32;
  localparam int LOG2N = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/fft_bitrev.sv
// Bit-reversal of a bin index; shared by the frame controller
// and the output reorder buffer.
module fft_bitrev #(
  parameter int LOG2N = 5
) (
  input  logic [LOG2N-1:0] idx,
  output logic [LOG2N-1:0] rev
);

  for (genvar i = 0; i < LOG2N; i++) begin : g_rev
    assign rev[i] = idx[LOG2N-1-i];
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: builds 32-sample frames for STAGE1, pads gaps,
// flushes the pipe and tags last-stage output with frame markers.
module fft_frame_ctrl #(
  parameter int N         = fft_pkg::N,
  parameter int LOG2N     = fft_pkg::LOG2N,
  parameter int FLUSH_MAX = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pipe_valid,
  output logic             pipe_zero,
  input  logic             fft_valid_i,
  output logic             out_valid,
  output logic [LOG2N-1:0] out_idx,
  output logic             out_sof,
  output logic             out_eof,
  output logic             busy,
  output logic             err_gap,
  output logic             err_timeout,
  output logic [CNT_W-1:0] frames_done
);
  import fft_pkg::*;

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  localparam logic [6:0] FL_LAST = 7'(FLUSH_MAX - 1);

  state_t           state;
  logic [LOG2N-1:0] in_cnt;
  logic [LOG2N-1:0] out_cnt;
  logic [LOG2N-1:0] rev_idx;
  logic [1:0]       outstanding;
  logic [6:0]       flush_cnt;
  logic             gap_q;
  logic             tmo_q;
  logic [CNT_W-1:0] done_q;

  logic issue;
  logic pad;
  logic flush;
  logic frm_in;
  logic ov;
  logic eof;

  always_comb begin
    issue = 1'b0;
    pad   = 1'b0;
    unique case (1'b1)
      state == IDLE: issue = in_valid;
      state == FILL: begin
        issue = in_valid | (in_cnt != '0);
        pad   = ~in_valid & (in_cnt != '0);
      end
      default: ;
    endcase
  end

  assign flush  = (state == FLUSH);
  assign frm_in = issue & (in_cnt == LAST);
  // flush-frame results arrive with nothing outstanding
  assign ov     = fft_valid_i & (outstanding != '0);
  assign eof    = ov & (out_cnt == LAST);

  assign in_ready    = rst & ~flush;
  assign pipe_valid  = rst & (issue | flush);
  assign pipe_zero   = rst & (pad | flush);
  assign out_valid   = rst & ov;
  assign out_sof     = rst & ov & (out_cnt == '0);
  assign out_eof     = rst & eof;
  assign out_idx     = rst ? rev_idx : '0;
  assign busy        = rst & (state != IDLE);
  assign err_gap     = rst & gap_q;
  assign err_timeout = rst & tmo_q;
  assign frames_done = rst ? done_q : '0;

  fft_bitrev #(.LOG2N(LOG2N)) u_bitrev (
    .idx (out_cnt),
    .rev (rev_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      outstanding <= '0;
      flush_cnt   <= '0;
      gap_q       <= 1'b0;
      tmo_q       <= 1'b0;
      done_q      <= '0;
    end else begin
      if (issue) in_cnt <= in_cnt + 1'b1;
      if (ov)    out_cnt <= out_cnt + 1'b1;
      if (eof)   done_q <= done_q + 1'b1;
      if (pad)   gap_q <= 1'b1;
      if (frm_in && !eof) begin
        if (outstanding == 2'd3) tmo_q <= 1'b1;
        else outstanding <= outstanding + 1'b1;
      end else if (eof && !frm_in) begin
        outstanding <= outstanding - 1'b1;
      end
      case (state)
        IDLE: if (in_valid) state <= FILL;
        FILL: begin
          if (in_cnt == '0 && !in_valid) begin
            flush_cnt <= '0;
            state <= (outstanding != '0) ? FLUSH : IDLE;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (eof && outstanding == 2'd1) begin
            state <= IDLE;
          end else if (flush_cnt == FL_LAST) begin
            tmo_q       <= 1'b1;
            outstanding <= '0;
            out_cnt     <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: expected output tags are
// queued as frames are fed and popped as tagged outputs appear.
module tb_fft_frame_ctrl;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        fft_valid_i = 1'b0;
  logic        in_ready;
  logic        pipe_valid;
  logic        pipe_zero;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic        out_sof;
  logic        out_eof;
  logic        busy;
  logic        err_gap;
  logic        err_timeout;
  logic [15:0] frames_done;

  fft_frame_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pipe_valid  (pipe_valid),
    .pipe_zero   (pipe_zero),
    .fft_valid_i (fft_valid_i),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .busy        (busy),
    .err_gap     (err_gap),
    .err_timeout (err_timeout),
    .frames_done (frames_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] idx;
    logic       sof;
    logic       eof;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   tcyc;
  bit   fsched [0:1023];
  int   c_pv, c_pz, c_rdy0, c_sof, c_eof, c_ov, max_out;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] brev(int v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r = {r[3:0], v[i]};
    return r;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.idx = brev(k);
      e.sof = (k == 0);
      e.eof = (k == N - 1);
      exp_q.push_back(e);
    end
  endtask

  // last stage: 32 valid cycles starting 19 after a frame's last sample
  task automatic sched(int last);
    for (int i = last + 19; i < last + 51; i++) fsched[i] = 1'b1;
  endtask

  task automatic clr();
    tcyc = 0;
    foreach (fsched[i]) fsched[i] = 1'b0;
    c_pv = 0; c_pz = 0; c_rdy0 = 0;
    c_sof = 0; c_eof = 0; c_ov = 0;
    max_out = 0;
  endtask

  task automatic cyc(bit iv);
    in_valid = iv;
    fft_valid_i = fsched[tcyc];
    @(negedge clk);
    if (pipe_valid) c_pv++;
    if (pipe_valid && pipe_zero && in_ready) c_pz++;
    if (!in_ready) c_rdy0++;
    if (int'(dut.outstanding) > max_out) max_out = int'(dut.outstanding);
    if (out_valid) begin
      c_ov++;
      c_sof += int'(out_sof);
      c_eof += int'(out_eof);
      if (exp_q.size() == 0) begin
        chk("phantom_out", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_idx", 32'(out_idx), 32'(e.idx));
        chk("out_sof", 32'(out_sof), 32'(e.sof));
        chk("out_eof", 32'(out_eof), 32'(e.eof));
      end
    end
    @(posedge clk);
    #1;
    tcyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    fft_valid_i = 1'b1;
    @(negedge clk);
    chk("rst_outs", 32'({in_ready, pipe_valid, pipe_zero,
      out_valid, out_idx, out_sof, out_eof, busy,
      err_gap, err_timeout}), 32'd0);
    chk("rst_frames", 32'(frames_done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    fft_valid_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_single(string t);
    clr();
    push_frame();
    sched(31);
    for (int k = 0; k < N; k++) cyc(1'b1);
    chk({t, "_pv"}, c_pv, 32);
    chk({t, "_pz"}, c_pz, 0);
    for (int k = 0; k < 60; k++) cyc(1'b0);
    chk({t, "_flush_len"}, c_rdy0, 49);
    chk({t, "_pv_total"}, c_pv, 32 + 49);
    chk({t, "_sof"}, c_sof, 1);
    chk({t, "_eof"}, c_eof, 1);
    chk({t, "_frames"}, 32'(frames_done), 1);
    chk({t, "_busy"}, 32'(busy), 0);
    chk({t, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_single("single");

    do_reset();
    clr();
    push_frame();
    push_frame();
    sched(31);
    sched(63);
    for (int k = 0; k < 2 * N; k++) cyc(1'b1);
    chk("b2b_pv", c_pv, 64);
    for (int k = 0; k < 60; k++) cyc(1'b0);
    chk("b2b_peak", max_out, 2);
    chk("b2b_sof", c_sof, 2);
    chk("b2b_eof", c_eof, 2);
    chk("b2b_frames", 32'(frames_done), 2);
    chk("b2b_gap", 32'(err_gap), 0);
    chk("b2b_busy", 32'(busy), 0);
    chk("b2b_drain", exp_q.size(), 0);

    do_reset();
    clr();
    push_frame();
    sched(31);
    for (int k = 0; k < N; k++) cyc(!(k == 10 || k == 11));
    chk("gap_pv", c_pv, 32);
    chk("gap_pads", c_pz, 2);
    chk("gap_flag", 32'(err_gap), 1);
    for (int k = 0; k < 60; k++) cyc(1'b0);
    chk("gap_sticky", 32'(err_gap), 1);
    chk("gap_frames", 32'(frames_done), 1);
    chk("gap_drain", exp_q.size(), 0);

    do_reset();
    clr();
    push_frame();
    for (int k = 0; k < N; k++) cyc(1'b1);
    for (int k = 0; k < 80; k++) cyc(1'b0);
    chk("tmo_len", c_rdy0, 64);
    chk("tmo_flag", 32'(err_timeout), 1);
    chk("tmo_outst", 32'(dut.outstanding), 0);
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_frames", 32'(frames_done), 0);
    chk("tmo_ov", c_ov, 0);

    do_reset();
    clr();
    push_frame();
    for (int k = 0; k < 17; k++) cyc(1'b1);
    chk("mid_cnt", 32'(dut.in_cnt), 17);
    do_reset();
    chk("mid_in_cnt", 32'(dut.in_cnt), 0);
    chk("mid_out_cnt", 32'(dut.out_cnt), 0);
    chk("mid_outst", 32'(dut.outstanding), 0);
    chk("mid_flush", 32'(dut.flush_cnt), 0);
    chk("mid_flags", 32'({busy, err_gap, err_timeout}), 0);
    run_single("after_rst");

    do_reset();
    clr();
    push_frame();
    for (int i = 50; i < 200; i++) fsched[i] = 1'b1;
    for (int k = 0; k < N; k++) cyc(1'b1);
    for (int k = 0; k < 120; k++) cyc(1'b0);
    chk("ph_ov", c_ov, 32);
    chk("ph_frames", 32'(frames_done), 1);
    chk("ph_busy", 32'(busy), 0);
    chk("ph_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
